// File: rtl/csr_trap_sequencer.sv
// Machine-mode trap entry / MRET sequencer sharing the single-port CSR file with the core.
// Optional build macro VECTORED_IRQ_EN enables vectored interrupt dispatch when mtvec[1:0]==2'b01.
module csr_trap_sequencer #(
  parameter int unsigned XLEN        = 32,
  parameter logic [1:0]  MSTATUS_MPP = 2'b11
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret_req,
  input  logic [11:0]     core_csr_raddr,
  input  logic            core_csr_ren,
  input  logic [11:0]     core_csr_waddr,
  input  logic            core_csr_wen,
  input  logic [XLEN-1:0] core_csr_wd,
  input  logic [XLEN-1:0] csr_rd,
  output logic [11:0]     csr_addr,
  output logic            csr_ren,
  output logic [11:0]     csr_waddr,
  output logic            csr_wen,
  output logic [XLEN-1:0] csr_wd,
  output logic            busy,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MTVAL   = 12'h343;
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  typedef enum logic [3:0] {
    IDLE,
    T_RDST,
    T_RDVEC,
    T_WEPC,
    T_WCAU,
    T_WTVAL,
    T_WST,
    M_RDST,
    M_RDEPC,
    M_WST,
    REDIR
  } state_t;

  state_t          state_q;
  logic            busy_q;
  logic            redirect_valid_q;
  logic [XLEN-1:0] redirect_pc_q;
  logic [XLEN-1:0] cause_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] tval_q;
  logic [XLEN-1:0] mstatus_q;
  logic [XLEN-1:0] mtvec_q;

  logic            irq_masked;
  logic [XLEN-1:0] trap_mstatus_d;
  logic [XLEN-1:0] mret_mstatus_d;
  logic [XLEN-1:0] vector_d;

  // An interrupt arriving while MIE is clear aborts the sequence before any write.
  assign irq_masked = cause_q[XLEN-1] & ~mstatus_q[3];

  always_comb begin
    trap_mstatus_d        = mstatus_q;
    trap_mstatus_d[7]     = mstatus_q[3];
    trap_mstatus_d[3]     = 1'b0;
    trap_mstatus_d[12:11] = MSTATUS_MPP;

    mret_mstatus_d        = mstatus_q;
    mret_mstatus_d[3]     = mstatus_q[7];
    mret_mstatus_d[7]     = 1'b1;
    mret_mstatus_d[12:11] = MSTATUS_MPP;
  end

  always_comb begin
    vector_d = mtvec_q & ALIGN_MASK;
`ifdef VECTORED_IRQ_EN
    if (mtvec_q[1:0] == 2'b01 && cause_q[XLEN-1])
      vector_d = (mtvec_q & ALIGN_MASK) + ({1'b0, cause_q[XLEN-2:0]} << 2);
`endif
  end

  // IDLE passes the core's CSR traffic straight through; reset forces the port quiet.
  always_comb begin
    csr_addr  = '0;
    csr_ren   = 1'b0;
    csr_waddr = '0;
    csr_wen   = 1'b0;
    csr_wd    = '0;
    if (reset) begin
      case (state_q)
        IDLE: begin
          csr_addr  = core_csr_raddr;
          csr_ren   = core_csr_ren;
          csr_waddr = core_csr_waddr;
          csr_wen   = core_csr_wen;
          csr_wd    = core_csr_wd;
        end
        T_RDST, M_RDST: begin
          csr_addr = ADDR_MSTATUS;
          csr_ren  = 1'b1;
        end
        T_RDVEC: begin
          csr_addr = ADDR_MTVEC;
          csr_ren  = 1'b1;
        end
        M_RDEPC: begin
          csr_addr = ADDR_MEPC;
          csr_ren  = 1'b1;
        end
        T_WEPC: begin
          if (!irq_masked) begin
            csr_waddr = ADDR_MEPC;
            csr_wen   = 1'b1;
            csr_wd    = pc_q;
          end
        end
        T_WCAU: begin
          csr_waddr = ADDR_MCAUSE;
          csr_wen   = 1'b1;
          csr_wd    = cause_q;
        end
        T_WTVAL: begin
          csr_waddr = ADDR_MTVAL;
          csr_wen   = 1'b1;
          csr_wd    = tval_q;
        end
        T_WST: begin
          csr_waddr = ADDR_MSTATUS;
          csr_wen   = 1'b1;
          csr_wd    = trap_mstatus_d;
        end
        M_WST: begin
          csr_waddr = ADDR_MSTATUS;
          csr_wen   = 1'b1;
          csr_wd    = mret_mstatus_d;
        end
        default: ;
      endcase
    end
  end

  // Read data lags its address by one cycle, so each capture happens one state after the read.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q          <= IDLE;
      busy_q           <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      cause_q          <= '0;
      pc_q             <= '0;
      tval_q           <= '0;
      mstatus_q        <= '0;
      mtvec_q          <= '0;
    end else begin
      redirect_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (trap_req) begin
            cause_q <= trap_cause;
            pc_q    <= trap_pc;
            tval_q  <= trap_tval;
            busy_q  <= 1'b1;
            state_q <= T_RDST;
          end else if (mret_req) begin
            busy_q  <= 1'b1;
            state_q <= M_RDST;
          end
        end
        T_RDST:  state_q <= T_RDVEC;
        T_RDVEC: begin
          mstatus_q <= csr_rd;
          state_q   <= T_WEPC;
        end
        T_WEPC: begin
          mtvec_q <= csr_rd;
          if (irq_masked) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            state_q <= T_WCAU;
          end
        end
        T_WCAU:  state_q <= T_WTVAL;
        T_WTVAL: state_q <= T_WST;
        T_WST: begin
          redirect_pc_q    <= vector_d;
          redirect_valid_q <= 1'b1;
          state_q          <= REDIR;
        end
        M_RDST:  state_q <= M_RDEPC;
        M_RDEPC: begin
          mstatus_q <= csr_rd;
          state_q   <= M_WST;
        end
        M_WST: begin
          redirect_pc_q    <= csr_rd & ALIGN_MASK;
          redirect_valid_q <= 1'b1;
          state_q          <= REDIR;
        end
        REDIR: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy           = busy_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Self-checking bench for csr_trap_sequencer: directed scenarios plus randomized trap/MRET
// sequences checked against an architectural model of the CSR side effects.
module tb_csr_trap_sequencer;

  localparam logic [11:0] MSTATUS  = 12'h300;
  localparam logic [11:0] MTVEC    = 12'h305;
  localparam logic [11:0] MSCRATCH = 12'h340;
  localparam logic [11:0] MEPC     = 12'h341;
  localparam logic [11:0] MCAUSE   = 12'h342;
  localparam logic [11:0] MTVAL    = 12'h343;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        trapReq = 1'b0;
  logic [31:0] trapCause = '0;
  logic [31:0] trapPc = '0;
  logic [31:0] trapTval = '0;
  logic        mretReq = 1'b0;
  logic [11:0] coreCsrRaddr = '0;
  logic        coreCsrRen = 1'b0;
  logic [11:0] coreCsrWaddr = '0;
  logic        coreCsrWen = 1'b0;
  logic [31:0] coreCsrWd = '0;
  logic [31:0] csrRd = '0;
  logic [11:0] csrAddr;
  logic        csrRen;
  logic [11:0] csrWaddr;
  logic        csrWen;
  logic [31:0] csrWd;
  logic        busy;
  logic        redirectValid;
  logic [31:0] redirectPc;

  logic [31:0] csrMem [0:4095];

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  csr_trap_sequencer #(.XLEN(32), .MSTATUS_MPP(2'b11)) dut (
    .clock          (clock),
    .reset          (reset),
    .trap_req       (trapReq),
    .trap_cause     (trapCause),
    .trap_pc        (trapPc),
    .trap_tval      (trapTval),
    .mret_req       (mretReq),
    .core_csr_raddr (coreCsrRaddr),
    .core_csr_ren   (coreCsrRen),
    .core_csr_waddr (coreCsrWaddr),
    .core_csr_wen   (coreCsrWen),
    .core_csr_wd    (coreCsrWd),
    .csr_rd         (csrRd),
    .csr_addr       (csrAddr),
    .csr_ren        (csrRen),
    .csr_waddr      (csrWaddr),
    .csr_wen        (csrWen),
    .csr_wd         (csrWd),
    .busy           (busy),
    .redirect_valid (redirectValid),
    .redirect_pc    (redirectPc)
  );

  always #5 clock = ~clock;

  // CSR file model: registered read port, one write port.
  always @(posedge clock) begin
    if (csrRen) csrRd <= csrMem[csrAddr];
    if (csrWen) csrMem[csrWaddr] <= csrWd;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic coreWrite(input logic [11:0] addr, input logic [31:0] data);
    coreCsrWaddr = addr;
    coreCsrWd    = data;
    coreCsrWen   = 1'b1;
    tick();
    coreCsrWen   = 1'b0;
  endtask

  task automatic coreRead(input logic [11:0] addr, output logic [31:0] data);
    coreCsrRaddr = addr;
    coreCsrRen   = 1'b1;
    tick();
    coreCsrRen   = 1'b0;
    data         = csrRd;
  endtask

  task automatic setCsrs(input logic [31:0] ms, input logic [31:0] tv, input logic [31:0] ep,
                         input logic [31:0] ca, input logic [31:0] tl);
    coreWrite(MSTATUS, ms);
    coreWrite(MTVEC, tv);
    coreWrite(MEPC, ep);
    coreWrite(MCAUSE, ca);
    coreWrite(MTVAL, tl);
  endtask

  // Issues one request and checks latency, write count, redirect and resulting CSR contents
  // against what the privileged-architecture rules say should happen.
  task automatic applyStimulus(input string tag, input bit doTrap, input bit doMret,
                               input logic [31:0] cause, input logic [31:0] pc,
                               input logic [31:0] tval, input bit busyWrite);
    logic [31:0] ms, tv, ep, c0, t0;
    logic [31:0] expMs, expEpc, expCause, expTval, expPc;
    int expLat, expWr, idleAt, lat, wr, redirCount;
    bit gated;
    ms = csrMem[MSTATUS]; tv = csrMem[MTVEC]; ep = csrMem[MEPC];
    c0 = csrMem[MCAUSE];  t0 = csrMem[MTVAL];
    expMs = ms; expEpc = ep; expCause = c0; expTval = t0; expPc = '0;
    expLat = 0; expWr = 0;
    gated = doTrap && cause[31] && !ms[3];
    if (doTrap && !gated) begin
      expEpc   = pc;
      expCause = cause;
      expTval  = tval;
      expMs    = (ms & ~32'h1888) | (ms[3] ? 32'h80 : 32'h0) | 32'h1800;
      expPc    = tv & ~32'h3;
`ifdef VECTORED_IRQ_EN
      if (tv[1:0] == 2'b01 && cause[31]) expPc = expPc + (cause & 32'h7FFF_FFFF) * 4;
`endif
      expLat = 7;
      expWr  = 4;
    end else if (!doTrap && doMret) begin
      expMs  = (ms & ~32'h1888) | (ms[7] ? 32'h8 : 32'h0) | 32'h80 | 32'h1800;
      expPc  = ep & ~32'h3;
      expLat = 4;
      expWr  = 1;
    end
    idleAt = gated ? 4 : expLat + 1;

    trapReq = doTrap; mretReq = doMret;
    trapCause = cause; trapPc = pc; trapTval = tval;
    lat = 0; wr = 0; redirCount = 0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (n == 1) begin
        trapReq = 1'b0;
        mretReq = 1'b0;
        coreCsrWen = busyWrite;
        coreCsrWaddr = MSCRATCH;
        coreCsrWd = 32'h0000_0BAD;
        checkOutput({tag, "_busy_start"}, 32'(busy), 32'd1);
      end
      if (n == 4) coreCsrWen = 1'b0;
      if (csrWen) wr++;
      if (redirectValid) begin
        redirCount++;
        if (lat == 0) begin
          lat = n;
          checkOutput({tag, "_redirect_pc"}, redirectPc, expPc);
        end
      end
      if (n == idleAt - 1) checkOutput({tag, "_busy_last"}, 32'(busy), 32'd1);
      if (n == idleAt) checkOutput({tag, "_busy_done"}, 32'(busy), 32'd0);
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "_redirect_count"}, 32'(redirCount), (expLat != 0) ? 32'd1 : 32'd0);
    checkOutput({tag, "_write_count"}, 32'(wr), 32'(expWr));
    checkOutput({tag, "_mstatus"}, csrMem[MSTATUS], expMs);
    checkOutput({tag, "_mepc"}, csrMem[MEPC], expEpc);
    checkOutput({tag, "_mcause"}, csrMem[MCAUSE], expCause);
    checkOutput({tag, "_mtval"}, csrMem[MTVAL], expTval);
  endtask

  initial begin
    logic [31:0] rdata;
    logic [31:0] rMs, rTv, rEp, rCause, rPc, rTval;
    int kind;

    // Reset state, with the core trying to drive the port.
    coreCsrWen = 1'b1;
    coreCsrRen = 1'b1;
    #2;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_redirect_valid", 32'(redirectValid), 32'd0);
    checkOutput("reset_redirect_pc", redirectPc, 32'd0);
    checkOutput("reset_csr_wen", 32'(csrWen), 32'd0);
    checkOutput("reset_csr_ren", 32'(csrRen), 32'd0);
    coreCsrWen = 1'b0;
    coreCsrRen = 1'b0;
    #10;
    reset = 1'b1;
    tick();

    // Basic synchronous exception.
    setCsrs(32'h8, 32'h80, 32'h0, 32'h0, 32'h0);
    applyStimulus("t1", 1'b1, 1'b0, 32'h2, 32'h1004, 32'hDEAD, 1'b0);
    checkOutput("t1_mstatus_const", csrMem[MSTATUS], 32'h1880);
    checkOutput("t1_vector_const", redirectPc, 32'h80);

    // MRET back to an unaligned mepc.
    setCsrs(32'h80, 32'h80, 32'h2002, 32'h2, 32'h0);
    applyStimulus("t2", 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
    checkOutput("t2_mstatus_const", csrMem[MSTATUS], 32'h1888);
    checkOutput("t2_redirect_const", redirectPc, 32'h2000);

    // Masked interrupt: sequence aborts silently.
    setCsrs(32'h0, 32'h80, 32'h1111, 32'h2222, 32'h3333);
    applyStimulus("t3", 1'b1, 1'b0, 32'h8000_000B, 32'h4000, 32'h5, 1'b0);

    // Interrupt with mtvec in vectored mode.
    setCsrs(32'h8, 32'h101, 32'h0, 32'h0, 32'h0);
    applyStimulus("t4", 1'b1, 1'b0, 32'h8000_0007, 32'h3000, 32'h0, 1'b0);
`ifdef VECTORED_IRQ_EN
    checkOutput("t4_vector_const", redirectPc, 32'h11C);
`else
    checkOutput("t4_vector_const", redirectPc, 32'h100);
`endif

    // Simultaneous trap, MRET and core write; core write while busy must be blocked.
    setCsrs(32'h8, 32'h200, 32'h0, 32'h0, 32'h0);
    coreCsrWaddr = MSCRATCH;
    coreCsrWd    = 32'h55;
    coreCsrWen   = 1'b1;
    applyStimulus("t5", 1'b1, 1'b1, 32'h3, 32'h1234, 32'h77, 1'b1);
    checkOutput("t5_mscratch", csrMem[MSCRATCH], 32'h55);
    coreRead(MSCRATCH, rdata);
    checkOutput("t5_core_read", rdata, 32'h55);

    // Reset asserted in the middle of the write phase.
    setCsrs(32'h8, 32'h300, 32'hAAAA, 32'hBBBB, 32'hCCCC);
    trapReq = 1'b1; trapCause = 32'h5; trapPc = 32'h600; trapTval = 32'h9;
    for (int n = 1; n <= 4; n++) begin
      tick();
      if (n == 1) trapReq = 1'b0;
    end
    checkOutput("t6_wen_before_reset", 32'(csrWen), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("t6_busy", 32'(busy), 32'd0);
    checkOutput("t6_redirect_valid", 32'(redirectValid), 32'd0);
    checkOutput("t6_redirect_pc", redirectPc, 32'd0);
    checkOutput("t6_csr_wen", 32'(csrWen), 32'd0);
    checkOutput("t6_csr_ren", 32'(csrRen), 32'd0);
    checkOutput("t6_csr_waddr", 32'(csrWaddr), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    checkOutput("t6_mcause_untouched", csrMem[MCAUSE], 32'hBBBB);
    coreWrite(MSCRATCH, 32'h99);
    checkOutput("t6_passthrough_write", csrMem[MSCRATCH], 32'h99);
    applyStimulus("t6_retrap", 1'b1, 1'b0, 32'h6, 32'h700, 32'h10, 1'b0);

    // Randomized traps, interrupts and MRETs.
    for (int i = 0; i < 24; i++) begin
      rMs    = $urandom;
      rTv    = $urandom;
      rEp    = $urandom;
      rCause = $urandom;
      rPc    = $urandom;
      rTval  = $urandom;
      if ($urandom_range(0, 1) == 1) rTv[1:0] = 2'b01;
      kind = int'($urandom_range(0, 2));
      setCsrs(rMs, rTv, rEp, $urandom, $urandom);
      case (kind)
        0: applyStimulus($sformatf("r%0d_exc", i), 1'b1, 1'b0, rCause & 32'h7FFF_FFFF, rPc, rTval, 1'b0);
        1: applyStimulus($sformatf("r%0d_mret", i), 1'b0, 1'b1, rCause, rPc, rTval, 1'b0);
        default: applyStimulus($sformatf("r%0d_irq", i), 1'b1, 1'b0, rCause | 32'h8000_0000, rPc, rTval, 1'b0);
      endcase
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
